inst_fetch_ctrl: RTL and testbench

Instruction fetch sequencer in front of the combinational instruction ROM (32-bit byte address in, 32-bit instruction out, word-indexed by addr[7:2]).
- Owns the fetch PC and drives the ROM address.
- Captures each fetched word with its PC into a small prefetch queue.
- Presents entries to the IF/ID pipeline register over a valid/ready handshake.
- Accepts jump/branch redirects from later stages, which flush the queue.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/inst_fetch_ctrl.sv | 98 +++++++++
 tb/tb_inst_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encodings, queue entry layout and default boot address.
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_PAUSE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry circular FIFO of {pc,inst}; head visible one cycle after push, no bypass.
// Push while full is only legal together with a pop; flush empties the queue and beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fetch_entry_t   wdat,
  output logic [PTR_W:0] count,
  output logic           vld,
  output fetch_entry_t   rdat
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_pop;

  assign vld    = (count != '0);
  assign do_pop = pop & vld;
  assign rdat   = mem[rptr];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + PTR_W'(1);
      if (do_pop) rptr <= rptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wptr] <= wdat;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational ROM, and feeds IF/ID through a prefetch queue.
// One-cycle push-to-visible latency; out_ready backpressure stalls pushes only when the queue is full.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic              clk,
  input  logic              clrn,
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [PTR_W:0]    q_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [31:0]  fpc;
  logic         push;
  logic         pop;
  logic         redir;
  logic         full;
  fetch_entry_t wentry;
  fetch_entry_t head;
  logic         unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];

  assign full = (q_count == FULL_CNT);
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    redir     = 1'b0;
    case (state)
      FETCH_BOOT: begin
        state_nxt = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (!fetch_en) state_nxt = FETCH_PAUSE;
        redir = redirect_valid;
        // A full queue can still accept when the head leaves this same cycle.
        push  = fetch_en & ~redirect_valid & (~full | pop);
      end
      FETCH_PAUSE: begin
        if (fetch_en) state_nxt = FETCH_RUN;
        redir = redirect_valid;
      end
      default: begin
        state_nxt = FETCH_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= FETCH_BOOT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)      fpc <= RESET_PC;
    else if (redir) fpc <= {redirect_pc[31:2], 2'b00};
    else if (push)  fpc <= fpc + PC_STEP;
  end

  assign wentry = '{pc: fpc, inst: rom_inst};

  fetch_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_queue (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdat  (wentry),
    .count (q_count),
    .vld   (out_valid),
    .rdat  (head)
  );

  assign rom_addr = fpc;
  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small combinational ROM model.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        clrn;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  q_count;

  logic [31:0] rom [64];
  int checks;
  int failures;

  assign rom_inst = rom[rom_addr[7:2]];

  inst_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .PTR_W    (2)
  ) dut (
    .clk            (clk),
    .clrn           (clrn),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hCAFE_0000 | 32'(i);
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h1400_0801;
    rom[2] = 32'h1400_2422;
    rom[3] = 32'h0010_0c41;
    rom[6] = 32'h0010_0c80;

    clrn           = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    #1;
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_count", {29'b0, q_count}, 32'h0);
    tick();
    tick();
    clrn = 1'b1;

    // Startup: BOOT edge, then one push per edge
    tick();
    check("boot_valid", {31'b0, out_valid}, 32'h0);
    check("boot_rom_addr", rom_addr, 32'h0);
    tick();
    check("start0_valid", {31'b0, out_valid}, 32'h1);
    check("start0_pc", out_pc, 32'h0);
    check("start0_inst", out_inst, 32'h0);
    check("start0_rom_addr", rom_addr, 32'h4);
    tick();
    check("start1_pc", out_pc, 32'h4);
    check("start1_inst", out_inst, 32'h1400_0801);
    check("start1_count", {29'b0, q_count}, 32'h1);
    tick();
    check("start2_pc", out_pc, 32'h8);
    check("start2_inst", out_inst, 32'h1400_2422);

    // Backpressure: restart at 0 with downstream stalled
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    check("bp_flush_valid", {31'b0, out_valid}, 32'h0);
    check("bp_flush_count", {29'b0, q_count}, 32'h0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_full_count", {29'b0, q_count}, 32'h4);
    check("bp_full_rom_addr", rom_addr, 32'h10);
    check("bp_full_head", out_pc, 32'h0);
    check("bp_full_inst3", rom[3], 32'h0010_0c41);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("bp_drain%0d_pc", i), out_pc, 32'(4 * i));
      check($sformatf("bp_drain%0d_count", i), {29'b0, q_count}, 32'h4);
    end
    check("bp_drain_rom_addr", rom_addr, 32'h20);

    // Redirect with three entries queued
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rd_pre_count", {29'b0, q_count}, 32'h3);
    check("rd_pre_head", out_pc, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid", {31'b0, out_valid}, 32'h0);
    check("rd_count", {29'b0, q_count}, 32'h0);
    check("rd_rom_addr", rom_addr, 32'h18);
    tick();
    check("rd_tgt_valid", {31'b0, out_valid}, 32'h1);
    check("rd_tgt_pc", out_pc, 32'h18);
    check("rd_tgt_inst", out_inst, 32'h0010_0c80);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1B;
    tick();
    redirect_valid = 1'b0;
    check("mis_rom_addr", rom_addr, 32'h18);
    check("mis_count", {29'b0, q_count}, 32'h0);
    tick();
    check("mis_pc", out_pc, 32'h18);

    // Pause: two entries drain, fetch PC frozen
    tick();
    check("pause_pre_count", {29'b0, q_count}, 32'h2);
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("pause_d1_pc", out_pc, 32'h1C);
    check("pause_d1_count", {29'b0, q_count}, 32'h1);
    tick();
    check("pause_empty_valid", {31'b0, out_valid}, 32'h0);
    check("pause_rom_addr", rom_addr, 32'h20);
    tick();
    check("pause_hold_rom_addr", rom_addr, 32'h20);
    fetch_en = 1'b1;
    tick();
    check("resume_valid", {31'b0, out_valid}, 32'h0);
    tick();
    check("resume_pc", out_pc, 32'h20);
    check("resume_valid2", {31'b0, out_valid}, 32'h1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    tick();
    tick();
    check("ar_pre_count", {29'b0, q_count}, 32'h3);
    #2;
    clrn = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'h0);
    check("ar_count", {29'b0, q_count}, 32'h0);
    check("ar_rom_addr", rom_addr, 32'h0);
    check("ar_pc", out_pc, 32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #2;
    clrn = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("ar_boot_rom_addr", rom_addr, 32'h0);
    check("ar_boot_valid", {31'b0, out_valid}, 32'h0);
    tick();
    check("ar_first_pc", out_pc, 32'h0);
    check("ar_first_valid", {31'b0, out_valid}, 32'h1);
    check("ar_first_rom_addr", rom_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
